// File: rtl/conv_addr_pkg.sv
// Shared types and size helpers for the convolution-window address generator.
package conv_addr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Output dimension along one axis of a padded, strided convolution.
  function automatic int out_dim(input int ifm, input int ker, input int pad, input int stride);
    return (ifm + 2 * pad - ker) / stride + 1;
  endfunction

  // Beats in one complete scan (product of all seven loop bounds).
  function automatic longint beat_count(input int ker_w, input int ker_h, input int ch,
                                        input int grp, input int out_w, input int out_h,
                                        input int passes);
    return longint'(ker_w) * ker_h * ch * grp * out_w * out_h * passes;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Counter over 0..MAX that wraps to 0 when advanced at MAX.
module wrap_counter #(
  parameter int MAX = 1,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  assign at_max = (cnt == W'(MAX));

  // Count register: clear has priority over increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= at_max ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/conv_window_addrgen.sv
// Convolution-window read-address generator: walks taps, channels, groups,
// output pixels and passes, and presents one address beat per handshake.
module conv_window_addrgen
  import conv_addr_pkg::*;
#(
  parameter int IFM_W      = 28,
  parameter int IFM_H      = 28,
  parameter int KER_W      = 3,
  parameter int KER_H      = 3,
  parameter int STRIDE     = 1,
  parameter int PAD        = 0,
  parameter int CH_PER_MEM = 1,
  parameter int CH_GROUPS  = 1,
  parameter int OFM_PASSES = 1,
  parameter int ADDR_W     = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [ADDR_W-1:0]           addr,
  output logic                        pad_flag,
  output logic [$clog2(CH_GROUPS):0]  grp_idx,
  output logic                        first_tap,
  output logic                        last_tap,
  output logic                        busy,
  output logic                        done
);

  localparam int OUT_W = out_dim(IFM_W, KER_W, PAD, STRIDE);
  localparam int OUT_H = out_dim(IFM_H, KER_H, PAD, STRIDE);
  localparam int SW    = ADDR_W + 1;
  localparam int GW    = $clog2(CH_GROUPS) + 1;

  localparam int KX_W = cnt_w(KER_W);
  localparam int KY_W = cnt_w(KER_H);
  localparam int CH_W = cnt_w(CH_PER_MEM);
  localparam int GR_W = cnt_w(CH_GROUPS);
  localparam int OX_W = cnt_w(OUT_W);
  localparam int OY_W = cnt_w(OUT_H);
  localparam int PS_W = cnt_w(OFM_PASSES);

  localparam logic signed [SW-1:0] STRIDE_S = SW'(STRIDE);
  localparam logic signed [SW-1:0] PAD_S    = SW'(PAD);
  localparam logic signed [SW-1:0] IFM_W_S  = SW'(IFM_W);
  localparam logic signed [SW-1:0] IFM_H_S  = SW'(IFM_H);
  localparam logic [ADDR_W-1:0]    IFM_W_A  = ADDR_W'(IFM_W);
  localparam logic [ADDR_W-1:0]    PLANE_A  = ADDR_W'(IFM_W * IFM_H);

  state_t state, state_n;

  logic            load;
  logic            clr;
  logic            retire;
  logic            issued_all;
  logic            final_tuple;
  logic [6:0]      inc;
  logic [6:0]      at_max;

  logic [KX_W-1:0] kx;
  logic [KY_W-1:0] ky;
  logic [CH_W-1:0] ch;
  logic [GR_W-1:0] grp;
  logic [OX_W-1:0] ox;
  logic [OY_W-1:0] oy;
  logic [PS_W-1:0] ps;
  logic            unused_ok;

  logic signed [SW-1:0] ix;
  logic signed [SW-1:0] iy;
  logic                 pad_now;
  logic [ADDR_W-1:0]    lin_addr;

  // Each counter advances only when every inner counter wraps on this load.
  assign inc[0] = load;
  assign inc[1] = load & at_max[0];
  assign inc[2] = load & (&at_max[1:0]);
  assign inc[3] = load & (&at_max[2:0]);
  assign inc[4] = load & (&at_max[3:0]);
  assign inc[5] = load & (&at_max[4:0]);
  assign inc[6] = load & (&at_max[5:0]);
  assign final_tuple = &at_max;

  // The pass index only sequences rescans; it never enters the address.
  assign unused_ok = &{1'b0, ps};

  wrap_counter #(.MAX(KER_W - 1), .W(KX_W)) u_kx (
    .clk(clk), .reset(reset), .clr(clr), .inc(inc[0]), .cnt(kx), .at_max(at_max[0]));
  wrap_counter #(.MAX(KER_H - 1), .W(KY_W)) u_ky (
    .clk(clk), .reset(reset), .clr(clr), .inc(inc[1]), .cnt(ky), .at_max(at_max[1]));
  wrap_counter #(.MAX(CH_PER_MEM - 1), .W(CH_W)) u_ch (
    .clk(clk), .reset(reset), .clr(clr), .inc(inc[2]), .cnt(ch), .at_max(at_max[2]));
  wrap_counter #(.MAX(CH_GROUPS - 1), .W(GR_W)) u_grp (
    .clk(clk), .reset(reset), .clr(clr), .inc(inc[3]), .cnt(grp), .at_max(at_max[3]));
  wrap_counter #(.MAX(OUT_W - 1), .W(OX_W)) u_ox (
    .clk(clk), .reset(reset), .clr(clr), .inc(inc[4]), .cnt(ox), .at_max(at_max[4]));
  wrap_counter #(.MAX(OUT_H - 1), .W(OY_W)) u_oy (
    .clk(clk), .reset(reset), .clr(clr), .inc(inc[5]), .cnt(oy), .at_max(at_max[5]));
  wrap_counter #(.MAX(OFM_PASSES - 1), .W(PS_W)) u_ps (
    .clk(clk), .reset(reset), .clr(clr), .inc(inc[6]), .cnt(ps), .at_max(at_max[6]));

  // Input coordinates of the current tap, padding test and linear address.
  always_comb begin
    ix       = SW'(ox) * STRIDE_S + SW'(kx) - PAD_S;
    iy       = SW'(oy) * STRIDE_S + SW'(ky) - PAD_S;
    pad_now  = (ix < 0) || (ix >= IFM_W_S) || (iy < 0) || (iy >= IFM_H_S);
    lin_addr = ADDR_W'(ch) * PLANE_A + ADDR_W'(iy) * IFM_W_A + ADDR_W'(ix);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state, load/retire strobes and status outputs.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    clr     = 1'b0;
    retire  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_RUN;
          clr     = 1'b1;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        load = !issued_all && (!out_valid || out_ready);
        if (issued_all && out_valid && out_ready) begin
          retire  = 1'b1;
          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Remembers that the final tuple has been loaded so no further loads occur.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issued_all <= 1'b0;
    end else if (clr) begin
      issued_all <= 1'b0;
    end else if (load && final_tuple) begin
      issued_all <= 1'b1;
    end
  end

  // Output register: loads from the counters, holds under back-pressure.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      addr      <= '0;
      pad_flag  <= 1'b0;
      grp_idx   <= '0;
      first_tap <= 1'b0;
      last_tap  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      addr      <= pad_now ? '0 : lin_addr;
      pad_flag  <= pad_now;
      grp_idx   <= GW'(grp);
      first_tap <= ~|{kx, ky, ch, grp};
      last_tap  <= &at_max[3:0];
    end else if (retire) begin
      out_valid <= 1'b0;
    end
  end

endmodule
